// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin front-end of the 2:1 data mux.
package mux_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned MUX_W = 8;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Width needed to hold 0..burst inclusive.
    function automatic int unsigned burst_cnt_w(input int unsigned burst);
        return (burst < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/mux_w.sv
// W-bit combinational 2:1 mux: select=0 passes a, select=1 passes b.
module mux_w
    import mux_pkg::*;
#(
    parameter int unsigned W = MUX_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         select,
    output logic [W-1:0] y
);

    always_comb begin
        y = (select == SRC_B) ? b : a;
    end

endmodule

// File: rtl/mux_rr_arb.sv
// Bounded round-robin arbiter between two valid/ready sources feeding a single
// registered output stage; select reports which source owns the held word.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int unsigned W     = MUX_W,
    parameter int unsigned BURST = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         select,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready
);

    localparam int unsigned    CntW     = burst_cnt_w(BURST);
    localparam logic [CntW-1:0] BurstMax = CntW'(BURST);

    out_state_e      state_q, state_d;
    logic [W-1:0]    y_data_q;
    logic            select_q;
    logic            owner_q;
    logic [CntW-1:0] burst_q;

    logic            can_load;
    logic            grant;
    logic            grant_src;
    logic [W-1:0]    grant_data;

    // Grant decision; nothing is accepted while in reset or while the stage is stalled.
    always_comb begin
        can_load  = (state_q == StEmpty) || y_ready;
        grant     = 1'b0;
        grant_src = SRC_A;
        if (!rst && can_load) begin
            case ({a_valid, b_valid})
                2'b10: begin
                    grant     = 1'b1;
                    grant_src = SRC_A;
                end
                2'b01: begin
                    grant     = 1'b1;
                    grant_src = SRC_B;
                end
                2'b11: begin
                    grant     = 1'b1;
                    grant_src = (burst_q < BurstMax) ? owner_q : ~owner_q;
                end
                default: begin
                    grant     = 1'b0;
                    grant_src = SRC_A;
                end
            endcase
        end
    end

    assign a_ready = grant && (grant_src == SRC_A);
    assign b_ready = grant && (grant_src == SRC_B);

    mux_w #(
        .W(W)
    ) u_data_mux (
        .a      (a_data),
        .b      (b_data),
        .select (grant_src),
        .y      (grant_data)
    );

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = StFull;
        end else if (y_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            y_data_q <= '0;
            select_q <= SRC_A;
            owner_q  <= SRC_A;
            burst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                y_data_q <= grant_data;
                select_q <= grant_src;
                if (grant_src == owner_q) begin
                    if (burst_q < BurstMax) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end else begin
                    owner_q <= grant_src;
                    burst_q <= CntW'(1);
                end
            end
        end
    end

    assign y_valid = (state_q == StFull);
    assign y_data  = y_data_q;
    assign select  = select_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Randomised and directed checks of mux_rr_arb (BURST=2 and BURST=1 side by side)
// against a run-length based arbitration model.
module tb_mux_rr_arb;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid, y_ready;
    logic [7:0] a_data, b_data;

    logic       a_rdy [2];
    logic       b_rdy [2];
    logic       sel   [2];
    logic       yv    [2];
    logic [7:0] yd    [2];

    int checks = 0;
    int passes = 0;

    mux_rr_arb #(.W(8), .BURST(2)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_rdy[0]),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_rdy[0]),
        .select  (sel[0]),
        .y_valid (yv[0]),
        .y_data  (yd[0]),
        .y_ready (y_ready)
    );

    mux_rr_arb #(.W(8), .BURST(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_rdy[1]),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_rdy[1]),
        .select  (sel[1]),
        .y_valid (yv[1]),
        .y_data  (yd[1]),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history reduced to the last granted source and how many times in a
    // row it has been granted; contention hands over once that run reaches the limit.
    int         burst_of [2] = '{2, 1};
    int         run_m    [2];
    logic       last_m   [2];
    logic       yv_m     [2];
    logic [7:0] yd_m     [2];
    logic       ys_m     [2];
    bit         model_ok = 1'b0;

    function automatic void model_grant(input int k, output logic g, output logic src);
        logic can;
        can = !yv_m[k] || y_ready;
        g   = 1'b0;
        src = 1'b0;
        if (!rst && can) begin
            if (a_valid && b_valid) begin
                g   = 1'b1;
                src = (run_m[k] < burst_of[k]) ? last_m[k] : !last_m[k];
            end else if (a_valid) begin
                g   = 1'b1;
                src = 1'b0;
            end else if (b_valid) begin
                g   = 1'b1;
                src = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic g, s;
        for (int k = 0; k < 2; k++) begin
            model_grant(k, g, s);
            if (rst) begin
                run_m[k]  <= 0;
                last_m[k] <= 1'b0;
                yv_m[k]   <= 1'b0;
                yd_m[k]   <= 8'h00;
                ys_m[k]   <= 1'b0;
            end else if (g) begin
                yv_m[k] <= 1'b1;
                yd_m[k] <= s ? b_data : a_data;
                ys_m[k] <= s;
                if (s == last_m[k]) begin
                    run_m[k] <= run_m[k] + 1;
                end else begin
                    last_m[k] <= s;
                    run_m[k]  <= 1;
                end
            end else if (y_ready && yv_m[k]) begin
                yv_m[k] <= 1'b0;
            end
        end
        if (rst) model_ok <= 1'b1;
    end

    always @(negedge clk) begin
        logic g, s;
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                model_grant(k, g, s);
                chk($sformatf("a_ready[%0d]", k), 32'(a_rdy[k]), 32'(g && !s));
                chk($sformatf("b_ready[%0d]", k), 32'(b_rdy[k]), 32'(g && s));
                chk($sformatf("y_valid[%0d]", k), 32'(yv[k]), 32'(yv_m[k]));
                chk($sformatf("y_data[%0d]", k), 32'(yd[k]), 32'(yd_m[k]));
                chk($sformatf("select[%0d]", k), 32'(sel[k]), 32'(ys_m[k]));
            end
        end
    end

    // One clock; the words offered by DUT0's accepted source advance after the edge.
    task automatic step();
        logic ra, rb;
        @(negedge clk);
        ra = a_rdy[0];
        rb = b_rdy[0];
        @(posedge clk);
        #1;
        if (ra) a_data = a_data + 8'h01;
        if (rb) b_data = b_data + 8'h01;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] exp_d0 [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
    logic       exp_s0 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_s1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'hA0;
        b_data  = 8'hB0;
        y_ready = 1'b1;

        // Reset held with both sources valid.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst a_ready", 32'(a_rdy[0]), 32'd0);
            chk("rst b_ready", 32'(b_rdy[0]), 32'd0);
            chk("rst y_valid", 32'(yv[0]), 32'd0);
            chk("rst y_data", 32'(yd[0]), 32'h00);
            chk("rst select", 32'(sel[0]), 32'd0);
        end
        rst = 1'b0;

        // Continuous contention: BURST=2 pairs, BURST=1 alternates.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("contend data", 32'(yd[0]), 32'(exp_d0[i]));
            chk("contend select", 32'(sel[0]), 32'(exp_s0[i]));
            chk("contend valid", 32'(yv[0]), 32'd1);
            if (i < 4) chk("alternate select", 32'(sel[1]), 32'(exp_s1[i]));
        end

        // A only.
        do_reset();
        b_valid = 1'b0;
        a_data  = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_only data", 32'(yd[0]), 32'(8'h11 + i));
            chk("a_only select", 32'(sel[0]), 32'd0);
            chk("a_only valid", 32'(yv[0]), 32'd1);
        end

        // Backpressure holds the word; release resumes without loss.
        do_reset();
        a_data  = 8'hA0;
        y_ready = 1'b0;
        step();
        chk("bp load", 32'(yd[0]), 32'hA0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp hold data", 32'(yd[0]), 32'hA0);
            chk("bp hold select", 32'(sel[0]), 32'd0);
            chk("bp a_ready", 32'(a_rdy[0]), 32'd0);
            chk("bp b_ready", 32'(b_rdy[0]), 32'd0);
        end
        y_ready = 1'b1;
        step();
        chk("bp next", 32'(yd[0]), 32'hA1);
        step();
        chk("bp next2", 32'(yd[0]), 32'hA2);

        // Reset mid-burst restarts the run at A.
        do_reset();
        b_valid = 1'b1;
        a_data  = 8'hA0;
        b_data  = 8'hB0;
        step();
        chk("mid first", 32'(sel[0]), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst y_valid", 32'(yv[0]), 32'd0);
        step();
        chk("mid after1", 32'(sel[0]), 32'd0);
        step();
        chk("mid after2", 32'(sel[0]), 32'd0);
        step();
        chk("mid after3", 32'(sel[0]), 32'd1);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst     = ($urandom_range(0, 99) == 0);
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            y_ready = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
